// File: rtl/pcie_trans_nvc_pkg.sv
// Shared types and constants for the pcie_trans_nvc transaction-layer datapath.
package pcie_trans_nvc_pkg;

    typedef enum logic [2:0] {
        StReset,
        StInit,
        StIdle,
        StActive,
        StError
    } state_e;

    // Bit positions inside error_src; VC bits follow ErrVcBase, dest bits follow the VC bits.
    localparam int unsigned ErrUnderflow  = 0;
    localparam int unsigned ErrMf         = 1;
    localparam int unsigned ErrVcBase     = 2;

    localparam int unsigned ArbRoundRobin = 1;

endpackage

// File: rtl/pcie_trans_nvc_fifo_fwft.sv
// First-word-fall-through FIFO with almost-full pause threshold and overflow flag.
module pcie_trans_nvc_fifo_fwft #(
    parameter int unsigned DATA_W = 6,
    parameter int unsigned DEPTH  = 4,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = AW + 1
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              push,
    input  logic              pop,
    input  logic [AW-1:0]     umbral,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              empty,
    output logic              pause,
    output logic              error
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              full, do_push, do_pop;

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == CW'(DEPTH));
        do_pop   = pop && !empty;
        // A pop in the same cycle frees the slot, so push into a full FIFO is legal then.
        do_push  = push && (!full || do_pop);
        error    = push && full && !do_pop;
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        pause    = (count_q >= (CW'(DEPTH) - CW'(umbral)));
        data_out = empty ? '0 : mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

endmodule

// File: rtl/pcie_trans_nvc.sv
// Transaction-layer datapath: main FIFO -> per-VC FIFOs -> arbiter -> per-destination FIFOs,
// with threshold back-pressure and a control FSM that latches sticky error sources.
module pcie_trans_nvc
    import pcie_trans_nvc_pkg::*;
#(
    parameter int unsigned DATA_W   = 6,
    parameter int unsigned NUM_VC   = 2,
    parameter int unsigned NUM_DEST = 2,
    parameter int unsigned MF_DEPTH = 4,
    parameter int unsigned VC_DEPTH = 16,
    parameter int unsigned D_DEPTH  = 4,
    parameter int unsigned ARB_MODE = 0,
    localparam int unsigned VC_W    = $clog2(NUM_VC),
    localparam int unsigned DST_W   = $clog2(NUM_DEST),
    localparam int unsigned MF_AW   = $clog2(MF_DEPTH),
    localparam int unsigned VC_AW   = $clog2(VC_DEPTH),
    localparam int unsigned D_AW    = $clog2(D_DEPTH),
    localparam int unsigned ERR_W   = 2 + NUM_VC + NUM_DEST
) (
    input  logic                       clk,
    input  logic                       reset_L,
    input  logic                       init,
    input  logic [MF_AW-1:0]           umbral_MF,
    input  logic [NUM_VC*VC_AW-1:0]    umbral_VC,
    input  logic [NUM_DEST*D_AW-1:0]   umbral_D,
    input  logic [DATA_W-1:0]          data_in,
    input  logic                       push,
    input  logic [NUM_DEST-1:0]        pop_D,
    output logic [NUM_DEST*DATA_W-1:0] data_out,
    output logic [NUM_DEST-1:0]        valid_out,
    output logic                       pause_out,
    output logic                       active_out,
    output logic                       idle_out,
    output logic                       error_out,
    output logic [ERR_W-1:0]           error_src
);

    state_e                    state_q, state_d;
    logic [MF_AW-1:0]          umb_mf_q, umb_mf_d;
    logic [NUM_VC*VC_AW-1:0]   umb_vc_q, umb_vc_d;
    logic [NUM_DEST*D_AW-1:0]  umb_d_q, umb_d_d;
    logic [VC_W-1:0]           rr_q, rr_d;
    logic [ERR_W-1:0]          err_q, err_d, err_set;
    logic                      active_q, idle_q, error_q;

    logic                      run, push_en, any_busy, underflow;
    logic [DATA_W-1:0]         mf_dout;
    logic                      mf_empty, mf_pop, mf_err;
    logic [VC_W-1:0]           mf_vc;
    logic [DATA_W-1:0]         vc_dout [NUM_VC];
    logic [DST_W-1:0]          vc_dst [NUM_VC];
    logic [NUM_VC-1:0]         vc_empty, vc_pause, vc_push, vc_pop, vc_err, vc_elig;
    logic [NUM_DEST-1:0]       d_empty, d_pause, d_push, d_pop, d_err;
    logic                      gnt_valid;
    logic [VC_W-1:0]           gnt, arb_base, arb_idx;

    assign run     = (state_q == StIdle) || (state_q == StActive) || (state_q == StError);
    assign push_en = (state_q != StReset);

    pcie_trans_nvc_fifo_fwft #(.DATA_W(DATA_W), .DEPTH(MF_DEPTH)) u_mf (
        .clk      (clk),
        .reset_L  (reset_L),
        .push     (push && push_en),
        .pop      (mf_pop),
        .umbral   (umb_mf_q),
        .data_in  (data_in),
        .data_out (mf_dout),
        .empty    (mf_empty),
        .pause    (pause_out),
        .error    (mf_err)
    );

    assign mf_vc   = mf_dout[DATA_W-1-DST_W -: VC_W];
    assign mf_pop  = run && !mf_empty && !vc_pause[mf_vc];
    assign vc_push = mf_pop ? (NUM_VC'(1) << mf_vc) : '0;

    for (genvar i = 0; i < NUM_VC; i++) begin : g_vc
        pcie_trans_nvc_fifo_fwft #(.DATA_W(DATA_W), .DEPTH(VC_DEPTH)) u_fifo (
            .clk      (clk),
            .reset_L  (reset_L),
            .push     (vc_push[i]),
            .pop      (vc_pop[i]),
            .umbral   (umb_vc_q[i*VC_AW +: VC_AW]),
            .data_in  (mf_dout),
            .data_out (vc_dout[i]),
            .empty    (vc_empty[i]),
            .pause    (vc_pause[i]),
            .error    (vc_err[i])
        );
        assign vc_dst[i]  = vc_dout[i][DATA_W-1 -: DST_W];
        assign vc_elig[i] = run && !vc_empty[i] && !d_pause[vc_dst[i]];
    end

    // Scan from the base index; strict priority always starts at VC0.
    always_comb begin
        gnt_valid = 1'b0;
        gnt       = '0;
        arb_idx   = '0;
        arb_base  = (ARB_MODE == ArbRoundRobin) ? rr_q : '0;
        for (int k = 0; k < NUM_VC; k++) begin
            arb_idx = arb_base + VC_W'(k);
            if (!gnt_valid && vc_elig[arb_idx]) begin
                gnt_valid = 1'b1;
                gnt       = arb_idx;
            end
        end
    end

    assign vc_pop    = gnt_valid ? (NUM_VC'(1) << gnt) : '0;
    assign d_push    = gnt_valid ? (NUM_DEST'(1) << vc_dst[gnt]) : '0;
    assign d_pop     = run ? pop_D : '0;
    assign underflow = run && |(pop_D & d_empty);

    for (genvar j = 0; j < NUM_DEST; j++) begin : g_dest
        pcie_trans_nvc_fifo_fwft #(.DATA_W(DATA_W), .DEPTH(D_DEPTH)) u_fifo (
            .clk      (clk),
            .reset_L  (reset_L),
            .push     (d_push[j]),
            .pop      (d_pop[j]),
            .umbral   (umb_d_q[j*D_AW +: D_AW]),
            .data_in  (vc_dout[gnt]),
            .data_out (data_out[j*DATA_W +: DATA_W]),
            .empty    (d_empty[j]),
            .pause    (d_pause[j]),
            .error    (d_err[j])
        );
    end

    assign valid_out = ~d_empty;
    assign any_busy  = !mf_empty || !(&vc_empty) || !(&d_empty);

    always_comb begin
        err_set                               = '0;
        err_set[ErrUnderflow]                 = underflow;
        err_set[ErrMf]                        = mf_err;
        err_set[ErrVcBase +: NUM_VC]          = vc_err;
        err_set[ErrVcBase + NUM_VC +: NUM_DEST] = d_err;

        state_d = state_q;
        unique case (state_q)
            StReset:  state_d = StInit;
            StInit:   if (!init) state_d = StIdle;
            StIdle:   if (any_busy) state_d = StActive;
            StActive: if (!any_busy) state_d = StIdle;
            StError:  state_d = StError;
            default:  state_d = StReset;
        endcase
        if (state_q != StReset) begin
            if (init) begin
                state_d = StInit;
            end else if (|err_q) begin
                state_d = StError;
            end
        end

        umb_mf_d = umb_mf_q;
        umb_vc_d = umb_vc_q;
        umb_d_d  = umb_d_q;
        if (state_q == StInit && init) begin
            umb_mf_d = umbral_MF;
            umb_vc_d = umbral_VC;
            umb_d_d  = umbral_D;
        end

        err_d = (state_q == StError && init) ? '0 : (err_q | err_set);
        rr_d  = gnt_valid ? (gnt + VC_W'(1)) : rr_q;
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q  <= StReset;
            umb_mf_q <= '0;
            umb_vc_q <= '0;
            umb_d_q  <= '0;
            rr_q     <= '0;
            err_q    <= '0;
            active_q <= 1'b0;
            idle_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            umb_mf_q <= umb_mf_d;
            umb_vc_q <= umb_vc_d;
            umb_d_q  <= umb_d_d;
            rr_q     <= rr_d;
            err_q    <= err_d;
            active_q <= (state_d == StActive);
            idle_q   <= (state_d == StIdle);
            error_q  <= (state_d == StError);
        end
    end

    assign active_out = active_q;
    assign idle_out   = idle_q;
    assign error_out  = error_q;
    assign error_src  = err_q;

endmodule

// File: tb/tb_pcie_trans_nvc.sv
// Directed bench for pcie_trans_nvc: one strict-priority and one round-robin instance share stimulus.
module tb_pcie_trans_nvc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset_L, init, push;
    logic [1:0]      umbral_MF;
    logic [7:0]      umbral_VC;
    logic [3:0]      umbral_D;
    logic [5:0]      data_in;
    logic [1:0]      pop_D;

    logic [1:0][11:0] dout;
    logic [1:0][1:0]  vout;
    logic [1:0]       pause, act, idle, err;
    logic [1:0][5:0]  esrc;

    int checks = 0;
    int errors = 0;

    // Index 0: strict priority, index 1: round robin (pointer is 1 when the drain starts).
    logic [5:0] exp_arb [2][10] = '{
        '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h31, 6'h32, 6'h33},
        '{6'h20, 6'h21, 6'h22, 6'h23, 6'h31, 6'h24, 6'h32, 6'h25, 6'h33, 6'h26}
    };

    pcie_trans_nvc #(.ARB_MODE(0)) u_dut_sp (
        .clk(clk), .reset_L(reset_L), .init(init), .umbral_MF(umbral_MF),
        .umbral_VC(umbral_VC), .umbral_D(umbral_D), .data_in(data_in), .push(push),
        .pop_D(pop_D), .data_out(dout[0]), .valid_out(vout[0]), .pause_out(pause[0]),
        .active_out(act[0]), .idle_out(idle[0]), .error_out(err[0]), .error_src(esrc[0])
    );

    pcie_trans_nvc #(.ARB_MODE(1)) u_dut_rr (
        .clk(clk), .reset_L(reset_L), .init(init), .umbral_MF(umbral_MF),
        .umbral_VC(umbral_VC), .umbral_D(umbral_D), .data_in(data_in), .push(push),
        .pop_D(pop_D), .data_out(dout[1]), .valid_out(vout[1]), .pause_out(pause[1]),
        .active_out(act[1]), .idle_out(idle[1]), .error_out(err[1]), .error_src(esrc[1])
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_init(input logic [1:0] mf, input logic [7:0] vc, input logic [3:0] d);
        init      = 1'b1;
        umbral_MF = mf;
        umbral_VC = vc;
        umbral_D  = d;
        cyc();
        cyc();
        init = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        reset_L = 1'b0; init = 1'b0; push = 1'b0; data_in = '0; pop_D = '0;
        umbral_MF = '0; umbral_VC = '0; umbral_D = '0;
        repeat (2) cyc();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({dout[d], vout[d], pause[d], act[d], idle[d], err[d], esrc[d]} !== '0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d: got %h required 0", d,
                         {dout[d], vout[d], pause[d], act[d], idle[d], err[d], esrc[d]});
            end
        end
        reset_L = 1'b1;
        do_init(2'd0, 8'h22, 4'h0);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({idle[d], act[d], err[d], vout[d]} !== 5'b10000) begin
                errors++;
                $display("FAIL init_idle dut%0d: got %b required 10000", d,
                         {idle[d], act[d], err[d], vout[d]});
            end
        end
    endtask

    task automatic test_latency();
        push = 1'b1; data_in = 6'h05;
        cyc();
        push = 1'b0;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (vout[d] !== 2'b00) begin
                errors++; $display("FAIL lat_k dut%0d: got %b required 00", d, vout[d]);
            end
        end
        cyc();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({vout[d], act[d]} !== 3'b001) begin
                errors++; $display("FAIL lat_k1 dut%0d: got %b required 001", d, {vout[d], act[d]});
            end
        end
        cyc();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({vout[d], act[d], dout[d]} !== {2'b01, 1'b1, 12'h005}) begin
                errors++;
                $display("FAIL lat_k2 dut%0d: got %h required %h", d, {vout[d], act[d], dout[d]},
                         {2'b01, 1'b1, 12'h005});
            end
        end
        pop_D = 2'b01;
        cyc();
        pop_D = 2'b00;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({vout[d], act[d]} !== 3'b001) begin
                errors++; $display("FAIL lat_pop dut%0d: got %b required 001", d, {vout[d], act[d]});
            end
        end
        cyc();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({idle[d], act[d], err[d], esrc[d]} !== 9'b100_000000) begin
                errors++;
                $display("FAIL lat_idle dut%0d: got %b required 100000000", d,
                         {idle[d], act[d], err[d], esrc[d]});
            end
        end
    endtask

    task automatic test_arbitration();
        int got;
        for (int k = 0; k < 4; k++) begin
            push = 1'b1; data_in = 6'h20 + 6'(k);
            cyc();
        end
        push = 1'b0;
        repeat (4) cyc();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({vout[d], dout[d][11:6]} !== {2'b10, 6'h20}) begin
                errors++;
                $display("FAIL arb_fill dut%0d: got %h required %h", d, {vout[d], dout[d][11:6]},
                         {2'b10, 6'h20});
            end
        end
        foreach (exp_arb[0][k]) begin
            if (k < 6) begin
                push = 1'b1;
                data_in = (k % 2 == 0) ? 6'h31 + 6'(k / 2) : 6'h24 + 6'(k / 2);
                cyc();
            end
        end
        push = 1'b0;
        repeat (4) cyc();
        got = 0;
        for (int n = 0; n < 40 && got < 10; n++) begin
            if (vout[0][1] && vout[1][1]) begin
                for (int d = 0; d < 2; d++) begin
                    checks++;
                    if (dout[d][11:6] !== exp_arb[d][got]) begin
                        errors++;
                        $display("FAIL arb_order dut%0d word%0d: got %h required %h", d, got,
                                 dout[d][11:6], exp_arb[d][got]);
                    end
                end
                got++;
                pop_D = 2'b10;
            end else begin
                pop_D = 2'b00;
            end
            cyc();
        end
        pop_D = 2'b00;
        checks++;
        if (got != 10) begin
            errors++; $display("FAIL arb_drain_timeout: got %0d words required 10", got);
        end
        repeat (2) cyc();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({idle[d], err[d]} !== 2'b10) begin
                errors++; $display("FAIL arb_end dut%0d: got %b required 10", d, {idle[d], err[d]});
            end
        end
    endtask

    task automatic test_backpressure();
        int got;
        // VC0 pauses at 4 words, each dest at 3; the system holds 3 + 4 + 4 = 11 words.
        do_init(2'd0, 8'h2C, 4'b0101);
        for (int k = 0; k < 10; k++) begin
            push = 1'b1; data_in = 6'(k);
            cyc();
        end
        push = 1'b0;
        repeat (6) cyc();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({pause[d], err[d]} !== 2'b00) begin
                errors++; $display("FAIL bp_10 dut%0d: got %b required 00", d, {pause[d], err[d]});
            end
        end
        push = 1'b1; data_in = 6'd10;
        cyc();
        push = 1'b0;
        repeat (3) cyc();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({pause[d], err[d], esrc[d], vout[d], dout[d][5:0]} !== {2'b10, 6'h00, 2'b01, 6'h00}) begin
                errors++;
                $display("FAIL bp_full dut%0d: got %h required %h", d,
                         {pause[d], err[d], esrc[d], vout[d], dout[d][5:0]},
                         {2'b10, 6'h00, 2'b01, 6'h00});
            end
        end
        got = 0;
        for (int n = 0; n < 60 && got < 11; n++) begin
            if (vout[0][0] && vout[1][0]) begin
                for (int d = 0; d < 2; d++) begin
                    checks++;
                    if (dout[d][5:0] !== 6'(got)) begin
                        errors++;
                        $display("FAIL bp_order dut%0d word%0d: got %h required %h", d, got,
                                 dout[d][5:0], 6'(got));
                    end
                end
                got++;
                pop_D = 2'b01;
            end else begin
                pop_D = 2'b00;
            end
            cyc();
        end
        pop_D = 2'b00;
        checks++;
        if (got != 11) begin
            errors++; $display("FAIL bp_drain_timeout: got %0d words required 11", got);
        end
        repeat (2) cyc();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({pause[d], idle[d], err[d]} !== 3'b010) begin
                errors++;
                $display("FAIL bp_end dut%0d: got %b required 010", d, {pause[d], idle[d], err[d]});
            end
        end
    endtask

    task automatic test_overflow();
        int got;
        init = 1'b1; umbral_MF = '0; umbral_VC = '0; umbral_D = '0;
        cyc();
        cyc();
        for (int k = 1; k <= 4; k++) begin
            push = 1'b1; data_in = 6'(k);
            cyc();
        end
        push = 1'b0;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({pause[d], err[d], esrc[d]} !== 8'b10_000000) begin
                errors++;
                $display("FAIL ovf_full dut%0d: got %b required 10000000", d, {pause[d], err[d], esrc[d]});
            end
        end
        init = 1'b0; push = 1'b1; data_in = 6'h0F;
        cyc();
        push = 1'b0;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({err[d], esrc[d]} !== 7'b0_000010) begin
                errors++;
                $display("FAIL ovf_src dut%0d: got %b required 0000010", d, {err[d], esrc[d]});
            end
        end
        cyc();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({err[d], idle[d]} !== 2'b10) begin
                errors++; $display("FAIL ovf_err dut%0d: got %b required 10", d, {err[d], idle[d]});
            end
        end
        repeat (3) cyc();
        init = 1'b1;
        cyc();
        init = 1'b0;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({err[d], esrc[d]} !== 7'b0) begin
                errors++;
                $display("FAIL ovf_clear dut%0d: got %b required 0000000", d, {err[d], esrc[d]});
            end
        end
        cyc();
        got = 0;
        for (int n = 0; n < 30 && got < 4; n++) begin
            if (vout[0][0] && vout[1][0]) begin
                for (int d = 0; d < 2; d++) begin
                    checks++;
                    if (dout[d][5:0] !== 6'(got + 1)) begin
                        errors++;
                        $display("FAIL ovf_order dut%0d word%0d: got %h required %h", d, got,
                                 dout[d][5:0], 6'(got + 1));
                    end
                end
                got++;
                pop_D = 2'b01;
            end else begin
                pop_D = 2'b00;
            end
            cyc();
        end
        pop_D = 2'b00;
        checks++;
        if (got != 4) begin
            errors++; $display("FAIL ovf_drain_timeout: got %0d words required 4", got);
        end
        repeat (4) cyc();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({vout[d], idle[d], err[d]} !== 4'b0010) begin
                errors++;
                $display("FAIL ovf_dropped dut%0d: got %b required 0010", d, {vout[d], idle[d], err[d]});
            end
        end
    endtask

    task automatic test_underflow_reset();
        pop_D = 2'b10;
        cyc();
        pop_D = 2'b00;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (esrc[d] !== 6'b000001) begin
                errors++; $display("FAIL udf_src dut%0d: got %b required 000001", d, esrc[d]);
            end
        end
        cyc();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (err[d] !== 1'b1) begin
                errors++; $display("FAIL udf_err dut%0d: got %b required 1", d, err[d]);
            end
        end
        push = 1'b1; data_in = 6'h21;
        cyc();
        push = 1'b0;
        repeat (3) cyc();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({vout[d], dout[d][11:6]} !== {2'b10, 6'h21}) begin
                errors++;
                $display("FAIL udf_traffic dut%0d: got %h required %h", d, {vout[d], dout[d][11:6]},
                         {2'b10, 6'h21});
            end
        end
        push = 1'b1; data_in = 6'h22;
        #2;
        reset_L = 1'b0;
        #1;
        push = 1'b0;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({dout[d], vout[d], pause[d], act[d], idle[d], err[d], esrc[d]} !== '0) begin
                errors++;
                $display("FAIL async_reset dut%0d: got %h required 0", d,
                         {dout[d], vout[d], pause[d], act[d], idle[d], err[d], esrc[d]});
            end
        end
        cyc();
        reset_L = 1'b1;
        do_init(2'd0, 8'h22, 4'h0);
        repeat (3) cyc();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({idle[d], vout[d], esrc[d]} !== 9'b1_00_000000) begin
                errors++;
                $display("FAIL post_reset dut%0d: got %b required 100000000", d,
                         {idle[d], vout[d], esrc[d]});
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_arbitration();
        test_backpressure();
        test_overflow();
        test_underflow_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
